// File: rtl/game_pkg.sv
// Shared definitions for the ship game: state codes, winner codes, screen size.
package game_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  // Match sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CDOWN = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_HIT   = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  // Winner codes reported by the core and by the match sequencer
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  // Round-win counter increment that sticks at the match limit
  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/game_match_ctrl_if.sv
// Bundle between VGA timing / switches / game core and the match sequencer.
interface game_match_ctrl_if;

  logic [9:0] x_pixel;
  logic [9:0] y_pixel;
  logic       start_btn;
  logic       core_game_over;
  logic [1:0] core_winner;
  logic       core_rst;
  logic       core_step;
  logic [2:0] state;
  logic [1:0] countdown;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] match_winner;

  // Sequencer side
  modport master (
    input  x_pixel, y_pixel, start_btn, core_game_over, core_winner,
    output core_rst, core_step, state, countdown, score1, score2, match_winner
  );

  // Environment / core side
  modport slave (
    output x_pixel, y_pixel, start_btn, core_game_over, core_winner,
    input  core_rst, core_step, state, countdown, score1, score2, match_winner
  );

endinterface

// File: rtl/game_btn_sync.sv
// Two-flop synchroniser for an asynchronous switch plus a one-clock rising-edge pulse.
module game_btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  // Synchronise the switch and keep last synchronised level for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/game_match_ctrl.sv
// Match sequencer: frame-rate gating of the game core, round scoring and match flow.
module game_match_ctrl
  import game_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int HIT_FRAMES     = 90,
  parameter int WIN_SCORE      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  game_match_ctrl_if.master bus
);

  localparam logic [9:0] TICK_Y  = 10'(SCREEN_HEIGHT);
  localparam logic [7:0] CD_1    = 8'(FRAMES_PER_SEC);
  localparam logic [7:0] CD_2    = 8'(2 * FRAMES_PER_SEC);
  localparam logic [7:0] CD_END  = 8'(3 * FRAMES_PER_SEC - 1);
  localparam logic [7:0] HIT_END = 8'(HIT_FRAMES - 1);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);

  logic       start_pulse;
  logic       match_q, match_prev_q, tick_q;
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] mw_q, mw_d;

  game_btn_sync u_start_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (bus.start_btn),
    .pulse_o (start_pulse)
  );

  // Frame tick: register the coordinate match, then edge-detect it (one tick per frame)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q      <= 1'b0;
      match_prev_q <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      match_q      <= (bus.x_pixel == 10'd0) && (bus.y_pixel == TICK_Y);
      match_prev_q <= match_q;
      tick_q       <= match_q & ~match_prev_q;
    end
  end

  // Next-state, scoring and match-winner decisions
  always_comb begin
    state_d = state_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    mw_d    = mw_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_pulse) begin
          state_d = ST_CDOWN;
          s1_d    = 4'd0;
          s2_d    = 4'd0;
          mw_d    = WIN_NONE;
        end
      end
      ST_CDOWN: if (tick_q && cnt_q == CD_END) state_d = ST_PLAY;
      ST_PLAY: begin
        // Game over is sampled every clock, not only on frame ticks
        if (bus.core_game_over) begin
          state_d = ST_HIT;
          case (bus.core_winner)
            WIN_P1:           s1_d = sat_inc(s1_q, WIN);
            WIN_P2:           s2_d = sat_inc(s2_q, WIN);
            WIN_NONE, WIN_DRAW: ;
          endcase
        end
      end
      ST_HIT: if (tick_q && cnt_q == HIT_END) state_d = ST_CHECK;
      ST_CHECK: begin
        if (s1_q == WIN) begin
          state_d = ST_OVER;
          mw_d    = WIN_P1;
        end else if (s2_q == WIN) begin
          state_d = ST_OVER;
          mw_d    = WIN_P2;
        end else begin
          state_d = ST_CDOWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, scores and match winner registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      mw_q    <= WIN_NONE;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      mw_q    <= mw_d;
    end
  end

  // Frame counter restarts on every state change so each state times from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_q <= 8'd0;
    else if (state_d != state_q) cnt_q <= 8'd0;
    else if (tick_q)             cnt_q <= cnt_q + 8'd1;
  end

  // Countdown digit shown while counting in a new round
  always_comb begin
    bus.countdown = 2'd0;
    if (state_q == ST_CDOWN) begin
      if (cnt_q < CD_1)      bus.countdown = 2'd3;
      else if (cnt_q < CD_2) bus.countdown = 2'd2;
      else                   bus.countdown = 2'd1;
    end
  end

  assign bus.core_rst     = (state_q == ST_IDLE) || (state_q == ST_CDOWN) || (state_q == ST_CHECK);
  assign bus.core_step    = tick_q && (state_q == ST_PLAY);
  assign bus.state        = state_q;
  assign bus.score1       = s1_q;
  assign bus.score2       = s2_q;
  assign bus.match_winner = mw_q;

endmodule

// File: tb/tb_game_match_ctrl.sv
// Scoreboard bench for the match sequencer with a compressed VGA scan model.
module tb_game_match_ctrl;
  import game_pkg::*;

  localparam int FPS   = 2;
  localparam int HITF  = 3;
  localparam int WINS  = 5;
  localparam int H_TOT = 8;
  localparam int LINES = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  game_match_ctrl_if bus();

  game_match_ctrl #(
    .FRAMES_PER_SEC (FPS),
    .HIT_FRAMES     (HITF),
    .WIN_SCORE      (WINS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] cd;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] mw;
    logic       crst;
    logic       step;
  } ev_t;

  ev_t expq[$];
  int  checks = 0;
  int  errors = 0;

  // Compressed scan: short lines, a few short rows plus one row at SCREEN_HEIGHT
  int xc = 0, ln = 0;
  initial begin
    bus.x_pixel = 10'd0;
    bus.y_pixel = 10'd0;
    forever begin
      @(negedge clk);
      xc = (xc == H_TOT - 1) ? 0 : xc + 1;
      if (xc == 0) ln = (ln == LINES - 1) ? 0 : ln + 1;
      bus.x_pixel = (xc == H_TOT - 1) ? 10'(SCREEN_WIDTH) : 10'(xc);
      bus.y_pixel = (ln == LINES - 2) ? 10'(SCREEN_HEIGHT) : 10'(ln);
    end
  end

  // Reference frame tick: coordinate match registered, then rising edge
  logic m1, m2, rtick;
  wire  mnow = (bus.x_pixel == 10'd0) && (bus.y_pixel == 10'(SCREEN_HEIGHT));
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= 1'b0; m2 <= 1'b0; rtick <= 1'b0;
    end else begin
      m1 <= mnow; m2 <= m1; rtick <= m1 & ~m2;
    end
  end

  // Monitor: every visible output change (or step pulse) pops one expectation
  logic        mon_first = 1'b1;
  logic [15:0] mon_prev;
  logic [15:0] mon_snap;
  ev_t         mon_act, mon_exp;
  initial begin
    forever begin
      @(posedge clk); #1;
      mon_snap = {bus.state, bus.countdown, bus.score1, bus.score2, bus.match_winner, bus.core_rst};
      if (mon_first || mon_snap != mon_prev || bus.core_step) begin
        mon_first = 1'b0;
        mon_act   = {mon_snap, bus.core_step};
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event t=%0t st=%0d cd=%0d s1=%0d s2=%0d mw=%0d rst=%0d step=%0d (queue empty)",
                   $time, mon_act.st, mon_act.cd, mon_act.s1, mon_act.s2, mon_act.mw, mon_act.crst, mon_act.step);
        end else begin
          mon_exp = expq.pop_front();
          if (mon_act !== mon_exp) begin
            errors++;
            $display("FAIL event t=%0t got st=%0d cd=%0d s1=%0d s2=%0d mw=%0d rst=%0d step=%0d want st=%0d cd=%0d s1=%0d s2=%0d mw=%0d rst=%0d step=%0d",
                     $time, mon_act.st, mon_act.cd, mon_act.s1, mon_act.s2, mon_act.mw, mon_act.crst, mon_act.step,
                     mon_exp.st, mon_exp.cd, mon_exp.s1, mon_exp.s2, mon_exp.mw, mon_exp.crst, mon_exp.step);
          end
        end
        if (bus.core_step) begin
          checks++;
          if (rtick !== 1'b1) begin
            errors++;
            $display("FAIL step_tick t=%0t core_step=1 frame_tick=%0d want 1", $time, rtick);
          end
        end
      end
      mon_prev = mon_snap;
    end
  end

  task automatic push(input logic [2:0] st, input logic [1:0] cd, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [1:0] mw, input logic crst, input logic step);
    ev_t e;
    e.st = st; e.cd = cd; e.s1 = s1; e.s2 = s2; e.mw = mw; e.crst = crst; e.step = step;
    expq.push_back(e);
  endtask

  task automatic clk_s();
    @(posedge clk); #1;
  endtask

  task automatic wait_ticks(input int n);
    int budget;
    for (int i = 0; i < n; i++) begin
      budget = 0;
      do begin
        clk_s();
        budget++;
      end while (!rtick && budget < 200);
      checks++;
      if (!rtick) begin
        errors++;
        $display("FAIL tick_timeout waited=%0d cycles, want a frame tick", budget);
      end
    end
  endtask

  task automatic press_start();
    wait_ticks(1);
    bus.start_btn = 1'b1;
    repeat (10) clk_s();
    bus.start_btn = 1'b0;
  endtask

  // One round from a fresh CDOWN (digit 3 already expected).
  // nxt: 0 back to CDOWN, 1 match over, 2 stop in HIT (caller continues)
  task automatic play_round(input logic [1:0] w, input int nsteps, input bit coincide,
                            input bit press_in_play, input logic [3:0] s1b, input logic [3:0] s2b,
                            input logic [3:0] s1a, input logic [3:0] s2a, input int nxt,
                            input logic [1:0] mwe);
    push(ST_CDOWN, 2'd2, s1b, s2b, WIN_NONE, 1'b1, 1'b0);
    push(ST_CDOWN, 2'd1, s1b, s2b, WIN_NONE, 1'b1, 1'b0);
    push(ST_PLAY,  2'd0, s1b, s2b, WIN_NONE, 1'b0, 1'b0);
    for (int i = 0; i < nsteps + (coincide ? 1 : 0); i++)
      push(ST_PLAY, 2'd0, s1b, s2b, WIN_NONE, 1'b0, 1'b1);
    push(ST_HIT, 2'd0, s1a, s2a, WIN_NONE, 1'b0, 1'b0);
    if (nxt != 2) begin
      push(ST_CHECK, 2'd0, s1a, s2a, WIN_NONE, 1'b1, 1'b0);
      if (nxt == 1) push(ST_OVER,  2'd0, s1a, s2a, mwe, 1'b0, 1'b0);
      else          push(ST_CDOWN, 2'd3, s1a, s2a, WIN_NONE, 1'b1, 1'b0);
    end
    wait_ticks(3 * FPS);
    if (press_in_play) begin
      wait_ticks(1);
      bus.start_btn = 1'b1;
      repeat (5) clk_s();
      bus.start_btn = 1'b0;
      wait_ticks(nsteps - 1);
    end else begin
      wait_ticks(nsteps);
    end
    // Raising game_over in the tick cycle makes it coincide with a core_step
    if (coincide) wait_ticks(1);
    else          clk_s();
    bus.core_game_over = 1'b1;
    bus.core_winner    = w;
    clk_s();
    bus.core_game_over = 1'b0;
    bus.core_winner    = WIN_NONE;
    if (nxt != 2) wait_ticks(HITF);
  endtask

  initial begin
    bus.start_btn      = 1'b0;
    bus.core_game_over = 1'b0;
    bus.core_winner    = WIN_NONE;
    push(ST_IDLE, 2'd0, 4'd0, 4'd0, WIN_NONE, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    repeat (3) clk_s();
    rst_n = 1'b1;
    repeat (5) clk_s();

    // Held start level -> one CDOWN entry, then first P1 win after 4 steps
    push(ST_CDOWN, 2'd3, 4'd0, 4'd0, WIN_NONE, 1'b1, 1'b0);
    press_start();
    play_round(WIN_P1, 4, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1, 4'd0, 0, WIN_NONE);

    // P1 wins up to the match limit
    for (int k = 2; k <= WINS; k++)
      play_round(WIN_P1, 1, 1'b0, 1'b0, 4'(k - 1), 4'd0, 4'(k), 4'd0,
                 (k == WINS) ? 1 : 0, (k == WINS) ? WIN_P1 : WIN_NONE);

    // Restart from OVER clears scores and winner
    push(ST_CDOWN, 2'd3, 4'd0, 4'd0, WIN_NONE, 1'b1, 1'b0);
    press_start();
    play_round(WIN_DRAW, 1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 0, WIN_NONE);
    play_round(WIN_P2,   1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd1, 0, WIN_NONE);
    play_round(WIN_P1,   2, 1'b0, 1'b1, 4'd0, 4'd1, 4'd1, 4'd1, 2, WIN_NONE);

    // Asynchronous reset in the middle of HIT, between clock edges
    wait_ticks(1);
    repeat (3) clk_s();
    #2;
    push(ST_IDLE, 2'd0, 4'd0, 4'd0, WIN_NONE, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== ST_IDLE || bus.core_rst !== 1'b1 || bus.score1 !== 4'd0 ||
        bus.score2 !== 4'd0 || bus.core_step !== 1'b0) begin
      errors++;
      $display("FAIL async_reset st=%0d rst=%0d s1=%0d s2=%0d step=%0d want st=0 rst=1 s1=0 s2=0 step=0",
               bus.state, bus.core_rst, bus.score1, bus.score2, bus.core_step);
    end
    repeat (4) clk_s();
    rst_n = 1'b1;
    repeat (20) clk_s();

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations remaining=%0d want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
